imm_encoder: RTL and testbench

Pipelined immediate encoder: packs a signed/unsigned 32-bit immediate into the RISC-V instruction bit positions for I/S/B/U/J formats, merging it with a caller-supplied base word that holds opcode, register and funct fields. It is the inverse of the immediate generator in the decode stage. It sits in the instruction-build path: trap/debug stub generation, self-test instruction synthesis, and the branch/jump offset patcher. It range-checks every immediate, substitutes a NOP on error, and keeps a saturating error count.

---
 rtl/imm_encoder.sv | 190 +++++++++++++++++++
 tb/tb_imm_encoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined RISC-V immediate encoder.
//
// Packs a 32-bit immediate into the I/S/B/U/J bit positions of a caller-supplied
// instruction template. It range-checks the immediate, checks B/J alignment and
// rejects unknown format codes. An errored word is replaced by a NOP
// (addi x0,x0,0). A saturating counter records errored words delivered downstream.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input word present
//   in_ready   encoder accepts the input word this cycle
//   in_sel     format code: 001 I, 010 S, 011 B, 100 U, 101 J, others invalid
//   in_imm     immediate (byte offset for B/J, full upper value for U)
//   in_base    instruction template; immediate bit positions are overwritten
//   out_valid  encoded word present
//   out_ready  consumer accepts the encoded word
//   out_inst   encoded instruction
//   out_err    00 ok, 01 range, 10 misaligned, 11 bad format
//   err_count  errored words delivered, saturating at 16'hFFFF

module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_sel,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [1:0]  out_err,
  output logic [15:0] err_count
);

  localparam logic [2:0] SelI = 3'b001;
  localparam logic [2:0] SelS = 3'b010;
  localparam logic [2:0] SelB = 3'b011;
  localparam logic [2:0] SelU = 3'b100;
  localparam logic [2:0] SelJ = 3'b101;

  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrRange    = 2'b01;
  localparam logic [1:0] ErrMisalign = 2'b10;
  localparam logic [1:0] ErrFormat   = 2'b11;

  localparam logic [31:0] NopInst = 32'h0000_0013;

  // Stage 1 registers
  logic        s1_valid_q;
  logic [2:0]  s1_sel_q;
  logic [31:0] s1_imm_q;
  logic [31:0] s1_base_q;

  // Stage 2 registers (drive the outputs)
  logic        s2_valid_q;
  logic [31:0] s2_inst_q;
  logic [1:0]  s2_err_q;
  logic [15:0] err_count_q;

  logic s2_free;
  logic s1_free;
  logic s1_load;
  logic s2_load;
  logic out_xfer;

  logic        range_err;
  logic        misalign;
  logic        bad_fmt;
  logic [31:0] pack_inst;
  logic [1:0]  s2_err_d;
  logic [31:0] s2_inst_d;

  // Handshake: stage 2 may take a new word when empty or draining this cycle;
  // stage 1 likewise when empty or when its word moves on.
  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s1_free  = !s1_valid_q || s2_free;
    s1_load  = in_valid && s1_free;
    s2_load  = s1_valid_q && s2_free;
    out_xfer = s2_valid_q && out_ready;
  end

  assign in_ready  = s1_free;
  assign out_valid = s2_valid_q;
  assign out_inst  = s2_inst_q;
  assign out_err   = s2_err_q;
  assign err_count = err_count_q;

  // Range checks are sign-extension checks: every bit above the encodable field
  // must equal the field's top bit.
  always_comb begin
    range_err = 1'b0;
    misalign  = 1'b0;
    bad_fmt   = 1'b0;
    pack_inst = s1_base_q;
    case (s1_sel_q)
      SelI: begin
        range_err        = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
        pack_inst[31:20] = s1_imm_q[11:0];
      end
      SelS: begin
        range_err        = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
        pack_inst[31:25] = s1_imm_q[11:5];
        pack_inst[11:7]  = s1_imm_q[4:0];
      end
      SelB: begin
        range_err        = !((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]));
        misalign         = s1_imm_q[0];
        pack_inst[31]    = s1_imm_q[12];
        pack_inst[30:25] = s1_imm_q[10:5];
        pack_inst[11:8]  = s1_imm_q[4:1];
        pack_inst[7]     = s1_imm_q[11];
      end
      SelU: begin
        range_err        = |s1_imm_q[11:0];
        pack_inst[31:12] = s1_imm_q[31:12];
      end
      SelJ: begin
        range_err        = !((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]));
        misalign         = s1_imm_q[0];
        pack_inst[31]    = s1_imm_q[20];
        pack_inst[30:21] = s1_imm_q[10:1];
        pack_inst[20]    = s1_imm_q[11];
        pack_inst[19:12] = s1_imm_q[19:12];
      end
      default: begin
        bad_fmt = 1'b1;
      end
    endcase
  end

  // Error priority: bad format over misalignment over range.
  always_comb begin
    s2_err_d = ErrNone;
    if (bad_fmt) begin
      s2_err_d = ErrFormat;
    end else if (misalign) begin
      s2_err_d = ErrMisalign;
    end else if (range_err) begin
      s2_err_d = ErrRange;
    end
    s2_inst_d = (s2_err_d != ErrNone) ? NopInst : pack_inst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= 3'b000;
      s1_imm_q   <= 32'h0;
      s1_base_q  <= 32'h0;
    end else begin
      if (s1_free) begin
        s1_valid_q <= in_valid;
      end
      if (s1_load) begin
        s1_sel_q  <= in_sel;
        s1_imm_q  <= in_imm;
        s1_base_q <= in_base;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_inst_q  <= 32'h0;
      s2_err_q   <= ErrNone;
    end else begin
      if (s2_free) begin
        s2_valid_q <= s1_valid_q;
      end
      // Data only changes on a load, so it holds while stalled.
      if (s2_load) begin
        s2_inst_q <= s2_inst_d;
        s2_err_q  <= s2_err_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= 16'h0;
    end else if (out_xfer && (s2_err_q != ErrNone) && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [1:0]  out_err;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .err_count (err_count)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [33:0] exp_q[$];  // {err, inst} in acceptance order
  int          occ;
  logic [31:0] exp_count;
  logic        held;
  logic [33:0] held_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: range as signed intervals, packing as masks and shifted fields.
  function automatic logic [33:0] model(input logic [2:0] sel, input logic [31:0] imm,
                                        input logic [31:0] base);
    int          s;
    logic [1:0]  err;
    logic [31:0] inst;
    s    = $signed(imm);
    err  = 2'd0;
    inst = base;
    case (sel)
      3'd1: begin
        if (s < -2048 || s > 2047) err = 2'd1;
        inst = (base & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
      end
      3'd2: begin
        if (s < -2048 || s > 2047) err = 2'd1;
        inst = (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      end
      3'd3: begin
        if (s < -4096 || s > 4095) err = 2'd1;
        if ((imm & 32'h1) != 0) err = 2'd2;
        inst = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
             | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
             | (((imm >> 11) & 32'h1) << 7);
      end
      3'd4: begin
        if ((imm % 4096) != 0) err = 2'd1;
        inst = (base & 32'hFFF) | (imm & 32'hFFFF_F000);
      end
      3'd5: begin
        if (s < -1048576 || s > 1048575) err = 2'd1;
        if ((imm & 32'h1) != 0) err = 2'd2;
        inst = (base & 32'hFFF) | (((imm >> 20) & 32'h1) << 31)
             | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
             | (((imm >> 12) & 32'hFF) << 12);
      end
      default: err = 2'd3;
    endcase
    if (err != 2'd0) inst = 32'h0000_0013;
    return {err, inst};
  endfunction

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 4))
      0:       return $urandom_range(0, 4095) - 2048;
      1:       return $urandom_range(0, 8191) - 4096;
      2:       return $urandom_range(0, 2097151) - 1048576;
      3:       return $urandom & 32'hFFFF_F000;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: drive, check handshakes and scoreboard, then check err_count.
  task automatic step(input logic r, input logic v, input logic [2:0] sel,
                      input logic [31:0] imm, input logic [31:0] base,
                      input logic ordy, output logic xfer);
    logic        acc;
    logic [33:0] e;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_sel    = sel;
    in_imm    = imm;
    in_base   = base;
    out_ready = ordy;
    #1;
    xfer = 1'b0;
    if (r) begin
      exp_q.delete();
      occ       = 0;
      exp_count = 0;
      held      = 1'b0;
    end else begin
      check_eq("in_ready", 32'(in_ready), 32'((occ < 2) || ordy));
      if (held) begin
        check_eq("hold_valid", 32'(out_valid), 32'd1);
        check_eq("hold_inst", out_inst, held_val[31:0]);
        check_eq("hold_err", 32'(out_err), 32'(held_val[33:32]));
      end
      acc  = v && in_ready;
      xfer = out_valid && ordy;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_inst", out_inst, e[31:0]);
          check_eq("out_err", 32'(out_err), 32'(e[33:32]));
          if (e[33:32] != 2'd0 && exp_count != 32'hFFFF) exp_count++;
          occ--;
        end
      end
      held     = out_valid && !ordy;
      held_val = {out_err, out_inst};
      if (acc) begin
        exp_q.push_back(model(sel, imm, base));
        occ++;
      end
    end
    @(posedge clk);
    #1;
    check_eq("err_count", 32'(err_count), exp_count);
    if (r) begin
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_inst", out_inst, 32'd0);
      check_eq("rst_err", 32'(out_err), 32'd0);
    end
  endtask

  task automatic idle(input logic ordy);
    logic x;
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, ordy, x);
  endtask

  task automatic reset_dut();
    logic x;
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, x);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
    check_eq("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Single word into an empty pipe; checks the two-cycle latency and fixed result.
  task automatic directed(input string tag, input logic [2:0] sel, input logic [31:0] imm,
                          input logic [31:0] base, input logic [31:0] exp_inst,
                          input logic [1:0] exp_err);
    logic x;
    step(1'b0, 1'b1, sel, imm, base, 1'b1, x);
    check_eq({tag, "_early"}, 32'(out_valid), 32'd0);
    idle(1'b0);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_inst"}, out_inst, exp_inst);
    check_eq({tag, "_err"}, 32'(out_err), 32'(exp_err));
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, x);
    check_eq({tag, "_xfer"}, 32'(x), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic x;
    int   first;
    int   last;
    int   nx;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    in_imm    = 32'd0;
    in_base   = 32'd0;
    out_ready = 1'b0;
    occ       = 0;
    exp_count = 0;
    held      = 1'b0;
    held_val  = '0;

    reset_dut();
    reset_dut();
    idle(1'b0);

    directed("i_type", 3'b001, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 2'b00);
    directed("b_type", 3'b011, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 2'b00);
    directed("u_type", 3'b100, 32'h1234_5000, 32'h0000_02B7, 32'h1234_52B7, 2'b00);

    reset_dut();
    directed("b_misal", 3'b011, 32'h0000_0007, 32'h0000_0063, 32'h0000_0013, 2'b10);
    directed("j_range", 3'b101, 32'h0010_0000, 32'h0000_006F, 32'h0000_0013, 2'b01);
    directed("bad_fmt", 3'b111, 32'h0000_0003, 32'h0000_0093, 32'h0000_0013, 2'b11);
    check_eq("err_count3", 32'(err_count), 32'd3);

    // Backpressure: two words fit, the third waits until out_ready rises.
    reset_dut();
    step(1'b0, 1'b1, 3'b001, 32'd1, 32'h0000_0093, 1'b0, x);
    step(1'b0, 1'b1, 3'b001, 32'd2, 32'h0000_0093, 1'b0, x);
    step(1'b0, 1'b1, 3'b001, 32'd3, 32'h0000_0093, 1'b0, x);
    check_eq("bp_full", 32'(in_ready), 32'd0);
    step(1'b0, 1'b1, 3'b001, 32'd3, 32'h0000_0093, 1'b1, x);
    check_eq("bp_out0", 32'(x), 32'd1);
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, x);
    check_eq("bp_out1", 32'(x), 32'd1);
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, x);
    check_eq("bp_out2", 32'(x), 32'd1);
    drain();

    // Throughput: 8 words back to back must leave on 8 consecutive cycles.
    reset_dut();
    first = -1;
    last  = -1;
    nx    = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) step(1'b0, 1'b1, 3'($urandom_range(1, 5)), rand_imm(), $urandom, 1'b1, x);
      else step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, x);
      if (x) begin
        if (first < 0) first = i;
        last = i;
        nx++;
      end
    end
    check_eq("tput_count", 32'(nx), 32'd8);
    check_eq("tput_span", 32'(last - first), 32'd7);

    // Reset with two words in flight; none may reappear.
    step(1'b0, 1'b1, 3'b111, 32'd0, 32'd0, 1'b1, x);
    step(1'b0, 1'b1, 3'b111, 32'd0, 32'd0, 1'b1, x);
    reset_dut();
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rand_imm(),
           $urandom, 1'($urandom_range(0, 3) != 0), x);
    end
    drain();

    // Saturation of the error counter.
    reset_dut();
    for (int i = 0; i < 65537; i++) step(1'b0, 1'b1, 3'b000, $urandom, $urandom, 1'b1, x);
    drain();
    check_eq("err_sat", 32'(err_count), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
